// File: rtl/spm_config_bus_writer_pkg.sv
// Shared config-bus definitions: state encoding and payload geometry.
// Used by the writer and by the SPM config receivers.
package spm_cfg_pkg;

  localparam int CFG_DATA_WIDTH = 512;
  localparam int CFG_WORD_WIDTH = 32;
  localparam int CFG_MAX_WORDS  = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_COMMIT = 2'd2
  } cfg_state_e;

endpackage

// File: rtl/spm_config_bus_writer_if.sv
// Command-word stream bundle (AXI-Stream subset) feeding the writer.
// master drives words, slave returns tready.
interface spm_config_bus_writer_if;
  import spm_cfg_pkg::*;

  logic [CFG_WORD_WIDTH-1:0] tdata;
  logic                      tvalid;
  logic                      tready;
  logic                      tlast;

  modport master (
    output tdata, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tlast,
    output tready
  );

endinterface

// File: rtl/spm_config_bus_writer.sv
// Frame-to-register writer: address word + up to 16 data words, held on the bus.
// Optional status port enabled by SPM_CFG_WRITER_STATUS_EN.
module spm_config_bus_writer
  import spm_cfg_pkg::*;
#(
  parameter logic [31:0] IDLE_ADDR   = 32'd0,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic                      a_clk,
  input  logic                      a_rst,
  input  logic [CFG_WORD_WIDTH-1:0] S_AXIS_CFG_tdata,
  input  logic                      S_AXIS_CFG_tvalid,
  output logic                      S_AXIS_CFG_tready,
  input  logic                      S_AXIS_CFG_tlast,
  output logic [31:0]               config_addr,
  output logic [CFG_DATA_WIDTH-1:0] config_data,
  output logic                      cfg_error
`ifdef SPM_CFG_WRITER_STATUS_EN
  ,
  output logic [31:0]               cfg_status
`endif
);

  localparam logic [4:0] MAX_IDX = 5'(CFG_MAX_WORDS);
  localparam logic [7:0] HOLD_LD = 8'(HOLD_CYCLES - 1);

  cfg_state_e state_q, state_d;
  logic [31:0] lat_q, lat_d;
  logic [31:0] addr_q, addr_d;
  logic [CFG_MAX_WORDS-1:0][CFG_WORD_WIDTH-1:0] buf_q, buf_d;
  logic [4:0] idx_q, idx_d;
  logic [7:0] hold_q, hold_d;
  logic drop_q, drop_d;
  logic err_q, err_d;
  logic rdy_q, rdy_d;
  logic acc;
  logic is_idle_addr;

  assign acc          = S_AXIS_CFG_tvalid && rdy_q;
  assign is_idle_addr = (S_AXIS_CFG_tdata == IDLE_ADDR);

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    addr_d  = addr_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    drop_d  = drop_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (acc) begin
          lat_d  = S_AXIS_CFG_tdata;
          buf_d  = '0;
          idx_d  = '0;
          drop_d = is_idle_addr;
          if (is_idle_addr) begin
            err_d = 1'b1;
          end
          if (!S_AXIS_CFG_tlast) begin
            state_d = ST_DATA;
          end else if (!is_idle_addr) begin
            state_d = ST_COMMIT;
            addr_d  = S_AXIS_CFG_tdata;
            hold_d  = HOLD_LD;
          end
        end
      end
      ST_DATA: begin
        if (acc) begin
          // Frames addressed to IDLE_ADDR are drained without touching the buffer.
          if (!drop_q) begin
            if (idx_q < MAX_IDX) begin
              buf_d[idx_q[3:0]] = S_AXIS_CFG_tdata;
              idx_d = idx_q + 5'd1;
            end else begin
              err_d = 1'b1;
            end
          end
          if (S_AXIS_CFG_tlast) begin
            if (drop_q) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_COMMIT;
              addr_d  = lat_q;
              hold_d  = HOLD_LD;
            end
          end
        end
      end
      ST_COMMIT: begin
        if (hold_q == 8'd0) begin
          state_d = ST_IDLE;
          addr_d  = IDLE_ADDR;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    rdy_d = (state_d != ST_COMMIT);
  end

  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      state_q <= ST_IDLE;
      lat_q   <= IDLE_ADDR;
      addr_q  <= IDLE_ADDR;
      buf_q   <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end

  assign S_AXIS_CFG_tready = rdy_q;
  assign config_addr       = addr_q;
  assign config_data       = buf_q;
  assign cfg_error         = err_q;

`ifdef SPM_CFG_WRITER_STATUS_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_COMMIT && hold_q == 8'd0) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cfg_status = {8'd0, idx_q, state_q, err_q, cnt_q};
`endif

endmodule

// File: tb/tb_spm_config_bus_writer.sv
// Randomized frame stimulus checked against a frame-level reference model.
// Build with SPM_CFG_WRITER_STATUS_EN to also check the status port.
module tb_spm_config_bus_writer;
  import spm_cfg_pkg::*;

  localparam logic [31:0] IDLE_A = 32'd0;
  localparam int HOLD = 2;

  logic a_clk = 1'b0;
  logic a_rst = 1'b1;
  logic [31:0] config_addr;
  logic [511:0] config_data;
  logic cfg_error;
`ifdef SPM_CFG_WRITER_STATUS_EN
  logic [31:0] cfg_status;
`endif

  spm_config_bus_writer_if cfg_if ();

  spm_config_bus_writer #(
    .IDLE_ADDR   (IDLE_A),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .a_clk             (a_clk),
    .a_rst             (a_rst),
    .S_AXIS_CFG_tdata  (cfg_if.tdata),
    .S_AXIS_CFG_tvalid (cfg_if.tvalid),
    .S_AXIS_CFG_tready (cfg_if.tready),
    .S_AXIS_CFG_tlast  (cfg_if.tlast),
    .config_addr       (config_addr),
    .config_data       (config_data),
    .cfg_error         (cfg_error)
`ifdef SPM_CFG_WRITER_STATUS_EN
    ,
    .cfg_status        (cfg_status)
`endif
  );

  always #5 a_clk = ~a_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [511:0] act,
                       input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Reference model: frames are collected whole, then judged by the rules.
  logic [31:0]  m_q[$];
  logic         m_rdy;
  int           m_hold;
  logic [31:0]  m_addr;
  logic [511:0] m_data;
  logic         m_err;
  logic         m_seen;
  int           m_commits;

  always @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      m_q.delete();
      m_rdy = 1'b0; m_hold = 0; m_addr = IDLE_A;
      m_data = '0; m_err = 1'b0; m_seen = 1'b0; m_commits = 0;
    end else begin
      if (m_hold > 0) begin
        m_hold--;
        if (m_hold == 0) begin
          m_addr = IDLE_A;
          m_commits++;
        end
      end else if (cfg_if.tvalid && m_rdy) begin
        m_q.push_back(cfg_if.tdata);
        if (m_q.size() == 1) begin
          m_seen = 1'b1;
          if (cfg_if.tdata == IDLE_A) m_err = 1'b1;
        end
        if (m_q[0] != IDLE_A && m_q.size() > 17) m_err = 1'b1;
        if (cfg_if.tlast) begin
          if (m_q[0] != IDLE_A) begin
            m_data = '0;
            for (int i = 0; i < 16; i++)
              if (i + 1 < m_q.size()) m_data[32*i +: 32] = m_q[i+1];
            m_addr = m_q[0];
            m_hold = HOLD;
            m_seen = 1'b0;
          end
          m_q.delete();
        end
      end
      m_rdy = (m_hold == 0);
    end
  end

  logic chk_en = 1'b0;

  always @(negedge a_clk) begin
    if (chk_en) begin
      check("m_tready", {511'd0, cfg_if.tready}, {511'd0, m_rdy});
      check("m_addr", {480'd0, config_addr}, {480'd0, m_addr});
      check("m_error", {511'd0, cfg_error}, {511'd0, m_err});
      if (!m_seen) check("m_data", config_data, m_data);
`ifdef SPM_CFG_WRITER_STATUS_EN
      check("m_cnt", {496'd0, cfg_status[15:0]}, {496'd0, 16'(m_commits)});
      check("m_serr", {511'd0, cfg_status[16]}, {511'd0, m_err});
      check("m_stop", {504'd0, cfg_status[31:24]}, 512'd0);
      check("m_state", {510'd0, cfg_status[18:17]},
            {510'd0, (m_hold > 0) ? 2'd2 : (m_q.size() > 0) ? 2'd1 : 2'd0});
`endif
    end
  end

  logic [31:0] wq[$];

  task automatic send_frame(input logic [31:0] addr, input int gap);
    int n;
    n = wq.size();
    for (int i = 0; i <= n; i++) begin
      int k;
      if (gap == 1 && i > 0) begin
        cfg_if.tvalid = 1'b0;
        @(posedge a_clk); #2;
      end else if (gap == 2) begin
        cfg_if.tvalid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge a_clk); #2; end
      end
      cfg_if.tvalid = 1'b1;
      cfg_if.tdata  = (i == 0) ? addr : wq[i-1];
      cfg_if.tlast  = (i == n);
      k = 0;
      do begin @(negedge a_clk); k++; end
      while (!cfg_if.tready && k < 100);
      if (!cfg_if.tready) begin
        checks++; errors++;
        $display("FAIL accept_timeout act=%0d exp=%0d", 0, 1);
      end
      @(posedge a_clk); #2;
    end
    cfg_if.tvalid = 1'b0;
    cfg_if.tlast  = 1'b0;
  endtask

  task automatic do_reset();
    a_rst = 1'b1;
    #1;
    check("rst_addr", {480'd0, config_addr}, {480'd0, IDLE_A});
    check("rst_tready", {511'd0, cfg_if.tready}, 512'd0);
    repeat (2) @(posedge a_clk);
    #2 a_rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge a_clk); #2; end
  endtask

  initial begin
    cfg_if.tdata = '0; cfg_if.tvalid = 1'b0; cfg_if.tlast = 1'b0;
    #1 chk_en = 1'b1;
    repeat (2) @(posedge a_clk);
    #2;
    check("rst_data", config_data, 512'd0);
    check("rst_err", {511'd0, cfg_error}, 512'd0);
    a_rst = 1'b0;
    idle(1);
    check("rel_tready", {511'd0, cfg_if.tready}, 512'd1);

    wq = '{32'h1000_0000, 32'h0000_0000};
    send_frame(32'd1101, 0);
    check("f1_addr_c1", {480'd0, config_addr}, {480'd0, 32'd1101});
    check("f1_data", config_data, {448'd0, 64'h00000000_10000000});
    check("f1_tready", {511'd0, cfg_if.tready}, 512'd0);
    idle(1);
    check("f1_addr_c2", {480'd0, config_addr}, {480'd0, 32'd1101});
    idle(1);
    check("f1_addr_end", {480'd0, config_addr}, 512'd0);
    check("f1_data_keep", config_data, {448'd0, 64'h00000000_10000000});

    wq = '{};
    for (int i = 0; i < 6; i++) wq.push_back(32'hA0 + i);
    send_frame(32'd1100, 1);
    check("f2_addr", {480'd0, config_addr}, {480'd0, 32'd1100});
    check("f2_w5", {480'd0, config_data[191:160]}, {480'd0, 32'hA5});
    idle(3);

    wq = '{};
    send_frame(32'd1103, 0);
    check("f3_addr", {480'd0, config_addr}, {480'd0, 32'd1103});
    check("f3_data", config_data, 512'd0);
    check("f3_err", {511'd0, cfg_error}, 512'd0);
    idle(3);

    wq = '{32'h11, 32'h22};
    send_frame(32'd0, 0);
    idle(3);
    check("f4_addr", {480'd0, config_addr}, 512'd0);
    check("f4_err", {511'd0, cfg_error}, 512'd1);

    do_reset();
    idle(1);
    wq = '{};
    for (int i = 0; i < 18; i++) wq.push_back(32'(i + 1));
    send_frame(32'h0000_0200, 2);
    check("f5_w0", {480'd0, config_data[31:0]}, {480'd0, 32'd1});
    check("f5_w15", {480'd0, config_data[511:480]}, {480'd0, 32'd16});
    check("f5_err", {511'd0, cfg_error}, 512'd1);
    idle(4);
    check("f5_err_sticky", {511'd0, cfg_error}, 512'd1);

    do_reset();
    idle(1);
    wq = '{32'h77};
    send_frame(32'h55, 0);
    #1 a_rst = 1'b1;
    #1 check("f6_abort", {480'd0, config_addr}, 512'd0);
    idle(2);
    a_rst = 1'b0;
    idle(3);
    check("f6_no_commit", {480'd0, config_addr}, 512'd0);
    wq = '{32'h99};
    send_frame(32'h56, 0);
    check("f6_next", {480'd0, config_addr}, {480'd0, 32'h56});
    idle(3);

    for (int f = 0; f < 40; f++) begin
      int n;
      logic [31:0] a;
      n = $urandom_range(0, 19);
      a = ($urandom_range(0, 7) == 0) ? IDLE_A : $urandom;
      wq = '{};
      for (int i = 0; i < n; i++) wq.push_back($urandom);
      send_frame(a, $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 3));
    end
    idle(5);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
